// File: rtl/brick_field_if.sv
// Playfield bus between brick_field (slave) and its driver (master): ball/paddle inputs in,
// brick layout, bounce pulses and score out. Pure wiring, no latency, no backpressure.
interface brick_field_if;
    logic        frame_clk;
    logic        new_game;
    logic [9:0]  BallX;
    logic [9:0]  BallY;
    logic [9:0]  Ball_size;
    logic [9:0]  PaddleX;
    logic [8:0]  brick_exists;
    logic [99:0] brick_x_vals;
    logic [99:0] brick_y_vals;
    logic [9:0]  brick_width;
    logic [9:0]  brick_height;
    logic        hit_x;
    logic        hit_y;
    logic        hit_paddle;
    logic [7:0]  score;
    logic        level_clear;

    modport master (
        output frame_clk, new_game, BallX, BallY, Ball_size, PaddleX,
        input  brick_exists, brick_x_vals, brick_y_vals, brick_width, brick_height,
        input  hit_x, hit_y, hit_paddle, score, level_clear
    );

    modport slave (
        input  frame_clk, new_game, BallX, BallY, Ball_size, PaddleX,
        output brick_exists, brick_x_vals, brick_y_vals, brick_width, brick_height,
        output hit_x, hit_y, hit_paddle, score, level_clear
    );
endinterface

// File: rtl/brick_field.sv
// Breakout brick array + paddle slot: per frame, scans 10 slots against the latched ball box.
// Results registered 12 Clk after frame_tick; no backpressure, frame ticks during a scan are dropped.
module brick_field #(
    parameter int BRICK_W   = 120,
    parameter int BRICK_H   = 20,
    parameter int COL_X0    = 80,
    parameter int COL_X1    = 260,
    parameter int COL_X2    = 440,
    parameter int ROW_Y0    = 40,
    parameter int ROW_Y1    = 70,
    parameter int ROW_Y2    = 100,
    parameter int PADDLE_Y  = 440,
    parameter int PADDLE_X0 = 260
) (
    input  logic         Clk,
    input  logic         Reset,
    brick_field_if.slave bus
);

    // Slot i lives at bits [10i+9:10i]; slot 0 is row 0 / column 0.
    localparam logic [89:0] BRICK_XS = {
        10'(COL_X2), 10'(COL_X1), 10'(COL_X0),
        10'(COL_X2), 10'(COL_X1), 10'(COL_X0),
        10'(COL_X2), 10'(COL_X1), 10'(COL_X0)
    };
    localparam logic [89:0] BRICK_YS = {
        10'(ROW_Y2), 10'(ROW_Y2), 10'(ROW_Y2),
        10'(ROW_Y1), 10'(ROW_Y1), 10'(ROW_Y1),
        10'(ROW_Y0), 10'(ROW_Y0), 10'(ROW_Y0)
    };
    localparam logic [9:0]  PX_MAX = 10'(640 - BRICK_W);
    localparam logic [3:0]  PADDLE_IDX = 4'd9;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  fsync;
    logic        frame_tick;
    logic [9:0]  lat_bx, lat_by, lat_sz, lat_px;
    logic [3:0]  idx, hit_idx;
    logic        hit_flag, hit_dir_x;
    logic [8:0]  exists;
    logic [9:0]  paddle_x;
    logic [7:0]  score_q;
    logic        hit_x_q, hit_y_q, hit_p_q;
    logic [9:0]  px_clamped;
    logic [6:0]  base;
    logic [10:0] lo_x, hi_x, lo_y, hi_y, slot_x, slot_y;
    logic        slot_live, overlap, side_hit;

    // frame_clk crosses in through two flops; the third flop gives the edge reference.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync      <= '0;
            frame_tick <= 1'b0;
        end else begin
            fsync      <= {fsync[1:0], bus.frame_clk};
            frame_tick <= fsync[1] & ~fsync[2];
        end
    end

    always_comb begin
        px_clamped = bus.PaddleX;
        if (({1'b0, bus.PaddleX} + 11'(BRICK_W)) > 11'd640) px_clamped = PX_MAX;
    end

    always_comb begin
        lo_x = (lat_bx >= lat_sz) ? ({1'b0, lat_bx} - {1'b0, lat_sz}) : 11'd0;
        lo_y = (lat_by >= lat_sz) ? ({1'b0, lat_by} - {1'b0, lat_sz}) : 11'd0;
        hi_x = {1'b0, lat_bx} + {1'b0, lat_sz};
        hi_y = {1'b0, lat_by} + {1'b0, lat_sz};
        base = (idx < PADDLE_IDX) ? 7'(idx) * 7'd10 : 7'd0;
        if (idx == PADDLE_IDX) begin
            slot_x    = {1'b0, lat_px};
            slot_y    = 11'(PADDLE_Y);
            slot_live = 1'b1;
        end else begin
            slot_x    = {1'b0, BRICK_XS[base +: 10]};
            slot_y    = {1'b0, BRICK_YS[base +: 10]};
            slot_live = |(exists & (9'd1 << idx));
        end
        overlap  = slot_live
                 && (hi_x >= slot_x) && (lo_x < slot_x + 11'(BRICK_W))
                 && (hi_y >= slot_y) && (lo_y < slot_y + 11'(BRICK_H));
        side_hit = ({1'b0, lat_by} >= slot_y) && ({1'b0, lat_by} < slot_y + 11'(BRICK_H));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (frame_tick) state_nxt = SCAN;
            SCAN:    if (idx == PADDLE_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.new_game) state_nxt = IDLE;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lat_bx    <= '0;
            lat_by    <= '0;
            lat_sz    <= '0;
            lat_px    <= 10'(PADDLE_X0);
            idx       <= '0;
            hit_idx   <= '0;
            hit_flag  <= 1'b0;
            hit_dir_x <= 1'b0;
            exists    <= 9'h1FF;
            paddle_x  <= 10'(PADDLE_X0);
            score_q   <= '0;
            hit_x_q   <= 1'b0;
            hit_y_q   <= 1'b0;
            hit_p_q   <= 1'b0;
        end else begin
            hit_x_q <= 1'b0;
            hit_y_q <= 1'b0;
            hit_p_q <= 1'b0;
            if (bus.new_game) begin
                exists   <= 9'h1FF;
                score_q  <= '0;
                hit_flag <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: if (frame_tick) begin
                        lat_bx   <= bus.BallX;
                        lat_by   <= bus.BallY;
                        lat_sz   <= bus.Ball_size;
                        lat_px   <= px_clamped;
                        idx      <= '0;
                        hit_flag <= 1'b0;
                    end
                    SCAN: begin
                        idx <= idx + 4'd1;
                        if (!hit_flag && overlap) begin
                            hit_flag  <= 1'b1;
                            hit_idx   <= idx;
                            hit_dir_x <= side_hit;
                        end
                    end
                    DONE: begin
                        paddle_x <= lat_px;
                        if (hit_flag && hit_idx == PADDLE_IDX) begin
                            hit_p_q <= 1'b1;
                            hit_y_q <= 1'b1;
                        end else if (hit_flag) begin
                            exists  <= exists & ~(9'd1 << hit_idx);
                            if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                            hit_x_q <= hit_dir_x;
                            hit_y_q <= ~hit_dir_x;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.brick_exists = exists;
    assign bus.brick_x_vals = {paddle_x, BRICK_XS};
    assign bus.brick_y_vals = {10'(PADDLE_Y), BRICK_YS};
    assign bus.brick_width  = 10'(BRICK_W);
    assign bus.brick_height = 10'(BRICK_H);
    assign bus.hit_x        = hit_x_q;
    assign bus.hit_y        = hit_y_q;
    assign bus.hit_paddle   = hit_p_q;
    assign bus.score        = score_q;
    assign bus.level_clear  = (exists == 9'd0);

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: a frame-level model predicts each scan outcome and is
// compared against every output on every cycle, backed by hand-computed spot checks.
module tb_brick_field;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    brick_field_if bus();

    brick_field dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int col_x [3] = '{80, 260, 440};
    int row_y [3] = '{40, 70, 100};

    // Expected DUT state and one outstanding frame result.
    logic [8:0] m_exists = 9'h1FF;
    int  m_score = 0, m_px = 260;
    bit  e_hx, e_hy, e_hp;
    bit  p_valid = 0, p_dirx = 0;
    int  p_cyc = 0, p_slot = -1, p_px = 260;
    int  busy_end = -100, ng_cyc = -1;
    bit  check_en = 0;

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Raise frame_clk now and predict the outcome at tick + 12 from plain geometry.
    task automatic launch(output int c);
        int t, lx, hx, ly, hy, bx, by, sz, px, x, y;
        c = cyc;
        t = c + 3;
        bus.frame_clk = 1'b1;
        if (t <= busy_end) return;
        bx = int'(bus.BallX); by = int'(bus.BallY); sz = int'(bus.Ball_size);
        px = (int'(bus.PaddleX) + 120 > 640) ? 520 : int'(bus.PaddleX);
        lx = (bx - sz < 0) ? 0 : bx - sz;  hx = bx + sz;
        ly = (by - sz < 0) ? 0 : by - sz;  hy = by + sz;
        p_slot = -1;
        p_dirx = 0;
        for (int i = 0; i < 10; i++) begin
            x = (i == 9) ? px : col_x[i % 3];
            y = (i == 9) ? 440 : row_y[i / 3];
            if ((i == 9 || m_exists[i]) && hx >= x && lx < x + 120 && hy >= y && ly < y + 20) begin
                p_slot = i;
                p_dirx = (by >= y) && (by < y + 20);
                break;
            end
        end
        p_valid  = 1;
        p_cyc    = t + 12;
        p_px     = px;
        busy_end = t + 11;
    endtask

    // One full frame; returns at the first cycle the result is visible.
    task automatic do_frame(input int bx, input int by, input int sz, input int px, output int c);
        step();
        bus.BallX = 10'(bx); bus.BallY = 10'(by); bus.Ball_size = 10'(sz); bus.PaddleX = 10'(px);
        launch(c);
        repeat (6) step();
        bus.frame_clk = 1'b0;
        while (cyc < c + 15) step();
    endtask

    always @(negedge Clk) begin
        logic [99:0] ex, ey;
        e_hx = 0; e_hy = 0; e_hp = 0;
        if (!Reset && check_en) begin
            if (ng_cyc == cyc) begin
                m_exists = 9'h1FF;
                m_score  = 0;
                if (p_valid && p_cyc >= cyc) p_valid = 0;
                busy_end = cyc - 1;
            end
            if (p_valid && p_cyc == cyc) begin
                p_valid = 0;
                m_px = p_px;
                if (p_slot >= 0 && p_slot < 9) begin
                    m_exists[p_slot] = 1'b0;
                    if (m_score < 255) m_score++;
                    if (p_dirx) e_hx = 1; else e_hy = 1;
                end else if (p_slot == 9) begin
                    e_hp = 1;
                    e_hy = 1;
                end
            end
            for (int i = 0; i < 9; i++) begin
                ex[10*i +: 10] = 10'(col_x[i % 3]);
                ey[10*i +: 10] = 10'(row_y[i / 3]);
            end
            ex[99:90] = 10'(m_px);
            ey[99:90] = 10'd440;
            chk("exists", bus.brick_exists, m_exists);
            chk("score", bus.score, m_score);
            chk("x_vals", bus.brick_x_vals, ex);
            chk("y_vals", bus.brick_y_vals, ey);
            chk("hit_x", bus.hit_x, e_hx);
            chk("hit_y", bus.hit_y, e_hy);
            chk("hit_paddle", bus.hit_paddle, e_hp);
            chk("level_clear", bus.level_clear, m_exists == 9'd0);
            chk("width", bus.brick_width, 120);
            chk("height", bus.brick_height, 20);
        end
    end

    initial begin
        int c;
        bus.frame_clk = 0; bus.new_game = 0;
        bus.BallX = 0; bus.BallY = 0; bus.Ball_size = 0; bus.PaddleX = 10'd260;
        repeat (3) step();
        chk("rst_exists", bus.brick_exists, 9'h1FF);
        chk("rst_slot4_x", bus.brick_x_vals[49:40], 260);
        chk("rst_slot4_y", bus.brick_y_vals[49:40], 70);
        chk("rst_slot9_x", bus.brick_x_vals[99:90], 260);
        chk("rst_slot9_y", bus.brick_y_vals[99:90], 440);
        chk("rst_score", bus.score, 0);
        chk("rst_pulses", {bus.hit_x, bus.hit_y, bus.hit_paddle, bus.level_clear}, 0);
        Reset = 0;
        check_en = 1;
        step();

        // Ball box 316..324 x 118..126 clips the underside of brick 7.
        do_frame(320, 122, 4, 260, c);
        chk("bf_hit_y", bus.hit_y, 1);
        chk("bf_hit_x", bus.hit_x, 0);
        chk("bf_exists", bus.brick_exists, 9'h17F);
        chk("bf_score", bus.score, 1);
        repeat (3) step();

        // Box 253..261 touches brick 4's left edge; brick 3 ends at 199.
        do_frame(257, 75, 4, 260, c);
        chk("side_hit_x", bus.hit_x, 1);
        chk("side_exists", bus.brick_exists, 9'h16F);
        chk("side_score", bus.score, 2);
        repeat (3) step();

        do_frame(350, 437, 4, 300, c);
        chk("pad_hit_p", bus.hit_paddle, 1);
        chk("pad_hit_y", bus.hit_y, 1);
        chk("pad_exists", bus.brick_exists, 9'h16F);
        chk("pad_x", bus.brick_x_vals[99:90], 300);
        repeat (3) step();

        do_frame(20, 300, 4, 600, c);
        chk("clamp_x", bus.brick_x_vals[99:90], 520);
        repeat (3) step();

        for (int i = 0; i < 9; i++) begin
            do_frame(col_x[i % 3] + 60, row_y[i / 3] + 10, 4, 260, c);
            repeat (3) step();
        end
        chk("lc_level_clear", bus.level_clear, 1);
        chk("lc_score", bus.score, 9);
        chk("lc_exists", bus.brick_exists, 0);

        step();
        bus.new_game = 1; ng_cyc = cyc + 1;
        step();
        bus.new_game = 0;
        step();
        chk("ng_exists", bus.brick_exists, 9'h1FF);
        chk("ng_score", bus.score, 0);
        chk("ng_level_clear", bus.level_clear, 0);

        // Pending brick-0 hit, aborted by new_game at tick + 5.
        step();
        bus.BallX = 10'd140; bus.BallY = 10'd50; bus.Ball_size = 10'd4;
        launch(c);
        while (cyc < c + 8) step();
        bus.new_game = 1; ng_cyc = cyc + 1;
        step();
        bus.new_game = 0; bus.frame_clk = 0;
        while (cyc < c + 20) step();
        chk("abort_exists", bus.brick_exists, 9'h1FF);
        chk("abort_score", bus.score, 0);

        // Second rise lands its tick mid-scan, aiming at brick 1; it must be dropped.
        step();
        launch(c);
        repeat (2) step();
        bus.frame_clk = 0;
        while (cyc < c + 5) step();
        bus.BallX = 10'd320;
        launch(c);
        repeat (3) step();
        bus.frame_clk = 0;
        while (cyc < c + 10) step();
        chk("dbl_exists", bus.brick_exists, 9'h1FE);
        chk("dbl_score", bus.score, 1);
        while (cyc < c + 30) step();
        chk("dbl_brick1_kept", bus.brick_exists, 9'h1FE);

        // Reset mid-scan with a brick-1 hit pending.
        launch(c);
        repeat (7) step();
        Reset = 1; bus.frame_clk = 0;
        m_exists = 9'h1FF; m_score = 0; m_px = 260; p_valid = 0; busy_end = -100;
        repeat (2) step();
        chk("mrst_exists", bus.brick_exists, 9'h1FF);
        chk("mrst_score", bus.score, 0);
        Reset = 0;
        repeat (20) step();
        chk("mrst_exists_after", bus.brick_exists, 9'h1FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
